can_tx_scheduler: RTL and testbench
===================================

Name: can_tx_scheduler

Overview:
- Shares the single transmit port of can_simple_top (tx_id, tx_data, tx_start_strobe, tx_succeed, tx_failed) among NUM_REQ local requesters.
- Arbitrates pending requests by CAN priority: lowest 11-bit ID wins.
- Sequences each frame: start strobe, completion wait, bounded retries, watchdog timeout.
- Reports per-requester accept, done and fail pulses; sits between application logic and can_simple_top in the clk_i domain.

Parameters:
- NUM_REQ, 4, number of requesters (1..8)
- MAX_RETRY, 3, retries after the first failed attempt before giving up
- RETRY_GAP, 1000, idle clk_i cycles between a failed attempt and the next strobe (>=1)
- TIMEOUT_CYCLES, 100000, clk_i cycles in WAIT without a completion before the attempt counts as failed

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  synchronous active-high reset
- req_i  in  NUM_REQ  level request per requester
- req_id_i  in  NUM_REQ*11  ID of requester k at bits [11k+10:11k]
- req_data_i  in  NUM_REQ*64  payload of requester k at bits [64k+63:64k]
- ack_o  out  NUM_REQ  one-cycle pulse: request captured
- done_o  out  NUM_REQ  one-cycle pulse: frame sent successfully
- fail_o  out  NUM_REQ  one-cycle pulse: frame abandoned
- busy_o  out  1  high whenever state != IDLE
- tx_id_o  out  11  to can_simple_top tx_id
- tx_data_o  out  64  to can_simple_top tx_data
- tx_start_strobe_o  out  1  to can_simple_top tx_start_strobe
- tx_succeed_i  in  1  from can_simple_top tx_succeed
- tx_failed_i  in  1  from can_simple_top tx_failed
- tx_ok_cnt_o  out  16  successful-frame counter (optional feature)
- tx_fail_cnt_o  out  16  abandoned-frame counter (optional feature)

Behaviour:
- Clocking and reset: one clock, clk_i. Reset is synchronous, active-high on rst_i.
- All outputs are registered.
- Reset values: state=IDLE; ack_o, done_o, fail_o = 0; busy_o=0; tx_start_strobe_o=0; tx_id_o=0; tx_data_o=0; retry and timeout counters = 0.
- States: IDLE, START, WAIT, GAP.
- IDLE, when req_i != 0:
  - Winner = requester with the numerically lowest req_id_i; ties go to the lowest index.
  - Latch the winner's ID into tx_id_o and its payload into tx_data_o.
  - ack_o[winner] goes high in the next cycle; winner index is stored; retry_cnt=0; go to START.
- START: tx_start_strobe_o=1 for exactly this one cycle; clear the timeout counter; go to WAIT.
  - Strobe therefore occurs 2 cycles after the sampling edge.
- WAIT:
  - tx_succeed_i: pulse done_o[winner]; go to IDLE.
  - tx_failed_i, or timeout counter reaching TIMEOUT_CYCLES-1: if retry_cnt < MAX_RETRY, increment retry_cnt and go to GAP; otherwise pulse fail_o[winner] and go to IDLE.
  - tx_succeed_i and tx_failed_i in the same cycle: succeed wins.
- GAP: count RETRY_GAP cycles, then go to START. tx_id_o and tx_data_o stay unchanged for the retry.
- tx_id_o and tx_data_o are stable from the ack cycle until the return to IDLE.
- The next arbitration can happen in the cycle after done_o or fail_o.
- Requester handshake:
  - Hold req_i and id/data stable until ack_o; deassert req_i in the cycle after ack.
  - req_i still high when the scheduler next samples in IDLE is treated as a new frame.
  - Dropping req_i before ack withdraws the request with no pulse.
  - Requests arriving while busy wait, unaffected.
- Boundaries:
  - tx_succeed_i or tx_failed_i outside WAIT is ignored.
  - MAX_RETRY=0 means one attempt only.
  - Timeout counter width is clog2(TIMEOUT_CYCLES+1).
  - At most one bit across ack_o, done_o and fail_o is high in any cycle.
- Reset mid-frame: immediate return to IDLE with outputs at reset values; no done_o or fail_o is emitted.

Optional Feature:
- Macro: CAN_TX_SCHED_STATS_EN.
- Defined:
  - tx_ok_cnt_o increments on every done_o pulse.
  - tx_fail_cnt_o increments on every fail_o pulse.
  - Both saturate at 16'hFFFF and clear on rst_i.
- Undefined: both ports remain and are tied to 0; no counter logic is synthesized.

Test Plan:
- Single request, req 0 with ID 0x352 and data 0x1122334455667788 → ack_o[0] one cycle later; strobe one cycle after that with tx_id_o=0x352; tx_succeed_i 20 cycles later → done_o[0] next cycle; busy_o returns to 0.
- Simultaneous req 1 (ID 0x100) and req 2 (ID 0x0FF) → req 2 acked first; req 1 acked in the cycle after done_o[2]. Equal IDs 0x200 on req 0 and req 3 → req 0 first.
- Failures: tx_failed_i on every attempt, MAX_RETRY=3 → exactly 4 strobes, each ≥RETRY_GAP+1 cycles apart; then fail_o pulse. tx_failed_i twice then tx_succeed_i → 3 strobes and a done_o pulse.
- Watchdog: no completion with TIMEOUT_CYCLES=50, MAX_RETRY=0 → fail_o pulses 50 cycles after the strobe cycle.
- Edge cases: tx_succeed_i and tx_failed_i asserted together → done_o only. rst_i asserted in WAIT → no done/fail pulse; all outputs 0 next cycle. Spurious tx_succeed_i in IDLE → ignored.
- With CAN_TX_SCHED_STATS_EN defined: 3 successes and 1 abandoned frame → tx_ok_cnt_o=3, tx_fail_cnt_o=1.

Source files
------------

// File: rtl/can_tx_scheduler.sv
// rtl/can_tx_scheduler.sv - priority scheduler sharing one CAN transmit port among NUM_REQ requesters
// Optional frame statistics counters enabled by defining CAN_TX_SCHED_STATS_EN.
module can_tx_scheduler #(
  parameter int NUM_REQ        = 4,
  parameter int MAX_RETRY      = 3,
  parameter int RETRY_GAP      = 1000,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [NUM_REQ-1:0]    req_i,
  input  logic [NUM_REQ*11-1:0] req_id_i,
  input  logic [NUM_REQ*64-1:0] req_data_i,
  output logic [NUM_REQ-1:0]    ack_o,
  output logic [NUM_REQ-1:0]    done_o,
  output logic [NUM_REQ-1:0]    fail_o,
  output logic                  busy_o,
  output logic [10:0]           tx_id_o,
  output logic [63:0]           tx_data_o,
  output logic                  tx_start_strobe_o,
  input  logic                  tx_succeed_i,
  input  logic                  tx_failed_i,
  output logic [15:0]           tx_ok_cnt_o,
  output logic [15:0]           tx_fail_cnt_o
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam int GW = $clog2(RETRY_GAP + 1);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [GW-1:0] GAP_LAST  = GW'(RETRY_GAP - 1);
  localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);

  typedef enum logic [1:0] {IDLE, START, WAIT, GAP} state_t;

  state_t               r_state;
  state_t               w_next;
  logic [IW-1:0]        r_win;
  logic [RW-1:0]        r_retry;
  logic [TW-1:0]        r_tmo;
  logic [GW-1:0]        r_gap;
  logic [NUM_REQ-1:0]   r_ack, r_done, r_fail;
  logic                 r_busy, r_strobe;
  logic [10:0]          r_tx_id;
  logic [63:0]          r_tx_data;

  logic                 w_any;
  logic [IW-1:0]        w_win;
  logic [10:0]          w_win_id;
  logic [63:0]          w_win_data;
  logic                 w_ok, w_retry, w_abandon;

  // Strict less-than keeps the lowest index on equal IDs.
  always_comb begin
    w_any      = 1'b0;
    w_win      = '0;
    w_win_id   = '0;
    w_win_data = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (req_i[k] && (!w_any || req_id_i[11*k +: 11] < w_win_id)) begin
        w_any      = 1'b1;
        w_win      = IW'(k);
        w_win_id   = req_id_i[11*k +: 11];
        w_win_data = req_data_i[64*k +: 64];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    w_ok      = 1'b0;
    w_retry   = 1'b0;
    w_abandon = 1'b0;
    case (r_state)
      IDLE:  if (w_any) w_next = START;
      START: w_next = WAIT;
      WAIT: begin
        if (tx_succeed_i) begin
          w_ok   = 1'b1;
          w_next = IDLE;
        end else if (tx_failed_i || r_tmo == TMO_LAST) begin
          if (r_retry < RETRY_MAX) begin
            w_retry = 1'b1;
            w_next  = GAP;
          end else begin
            w_abandon = 1'b1;
            w_next    = IDLE;
          end
        end
      end
      GAP:     if (r_gap == GAP_LAST) w_next = START;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_win     <= '0;
      r_retry   <= '0;
      r_tmo     <= '0;
      r_gap     <= '0;
      r_ack     <= '0;
      r_done    <= '0;
      r_fail    <= '0;
      r_busy    <= 1'b0;
      r_strobe  <= 1'b0;
      r_tx_id   <= '0;
      r_tx_data <= '0;
    end else begin
      r_ack    <= '0;
      r_done   <= '0;
      r_fail   <= '0;
      r_strobe <= (r_state == START);
      r_busy   <= (w_next != IDLE);
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_tx_id      <= w_win_id;
            r_tx_data    <= w_win_data;
            r_win        <= w_win;
            r_retry      <= '0;
            r_ack[w_win] <= 1'b1;
          end
        end
        START: r_tmo <= '0;
        WAIT: begin
          if (w_ok) begin
            r_done[r_win] <= 1'b1;
          end else if (w_retry) begin
            r_retry <= r_retry + 1'b1;
            r_gap   <= '0;
          end else if (w_abandon) begin
            r_fail[r_win] <= 1'b1;
          end else begin
            r_tmo <= r_tmo + 1'b1;
          end
        end
        GAP:     r_gap <= r_gap + 1'b1;
        default: ;
      endcase
    end
  end

  assign ack_o             = r_ack;
  assign done_o            = r_done;
  assign fail_o            = r_fail;
  assign busy_o            = r_busy;
  assign tx_id_o           = r_tx_id;
  assign tx_data_o         = r_tx_data;
  assign tx_start_strobe_o = r_strobe;

`ifdef CAN_TX_SCHED_STATS_EN
  logic [15:0] r_ok_cnt, r_fail_cnt;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_ok_cnt   <= '0;
      r_fail_cnt <= '0;
    end else begin
      if (|r_done && r_ok_cnt != 16'hFFFF)   r_ok_cnt   <= r_ok_cnt + 16'd1;
      if (|r_fail && r_fail_cnt != 16'hFFFF) r_fail_cnt <= r_fail_cnt + 16'd1;
    end
  end

  assign tx_ok_cnt_o   = r_ok_cnt;
  assign tx_fail_cnt_o = r_fail_cnt;
`else
  assign tx_ok_cnt_o   = '0;
  assign tx_fail_cnt_o = '0;
`endif

endmodule

// File: tb/tb_can_tx_scheduler.sv
// tb/tb_can_tx_scheduler.sv - directed and randomized bench for can_tx_scheduler
// Expected counter values depend on CAN_TX_SCHED_STATS_EN.
module tb_can_tx_scheduler;
  localparam int NR = 4;
  localparam int MR = 3;
  localparam int RG = 6;
  localparam int TO = 50;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic [NR-1:0]     req_i;
  logic [NR*11-1:0]  req_id_i;
  logic [NR*64-1:0]  req_data_i;
  logic [NR-1:0]     ack_o, done_o, fail_o;
  logic              busy_o;
  logic [10:0]       tx_id_o;
  logic [63:0]       tx_data_o;
  logic              tx_start_strobe_o;
  logic              tx_succeed_i, tx_failed_i;
  logic [15:0]       tx_ok_cnt_o, tx_fail_cnt_o;

  can_tx_scheduler #(
    .NUM_REQ(NR), .MAX_RETRY(MR), .RETRY_GAP(RG), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .req_id_i(req_id_i),
    .req_data_i(req_data_i), .ack_o(ack_o), .done_o(done_o), .fail_o(fail_o),
    .busy_o(busy_o), .tx_id_o(tx_id_o), .tx_data_o(tx_data_o),
    .tx_start_strobe_o(tx_start_strobe_o), .tx_succeed_i(tx_succeed_i),
    .tx_failed_i(tx_failed_i), .tx_ok_cnt_o(tx_ok_cnt_o), .tx_fail_cnt_o(tx_fail_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc++;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_ok  = 0;
  int exp_ab  = 0;
  logic [10:0] ids  [NR];
  logic [63:0] dats [NR];
  int g_oc  [MR+1];   // 0 succeed, 1 fail, 2 no response, 3 succeed+fail together
  int g_dly [MR+1];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk_i)
    if (!rst_i) chk("onehot", 64'($countones({ack_o, done_o, fail_o}) <= 1), 64'd1);

  task automatic step();
    @(posedge clk_i); #1;
  endtask

  task automatic set_req(input int k, input logic [10:0] id, input logic [63:0] d);
    ids[k] = id;
    dats[k] = d;
    req_id_i[11*k +: 11] = id;
    req_data_i[64*k +: 64] = d;
    req_i[k] = 1'b1;
  endtask

  // Reference arbitration: smallest (id, index) pair, encoded as one integer key.
  function automatic int pick(input logic [NR-1:0] m);
    int best_key = 32'h7fffffff;
    for (int k = 0; k < NR; k++)
      if (m[k] && (int'(ids[k]) * NR + k) < best_key) best_key = int'(ids[k]) * NR + k;
    return best_key % NR;
  endfunction

  task automatic wait_ack(input int w, input int exp_cyc, input string tag);
    int n = 0;
    @(negedge clk_i);
    while (ack_o == '0 && n < 10) begin @(negedge clk_i); n++; end
    chk({tag, "_ack"}, 64'(ack_o), 64'(1) << w);
    chk({tag, "_ack_cyc"}, 64'(cyc), 64'(exp_cyc));
    chk({tag, "_ack_id"}, 64'(tx_id_o), 64'(ids[w]));
  endtask

  // Called at the negedge of the ack cycle; plays out the attempt script in g_oc/g_dly.
  task automatic serve(input int w, input string tag);
    int s_exp, n, d;
    s_exp = cyc + 1;
    @(posedge clk_i); #1 req_i[w] = 1'b0;
    for (int a = 0; a <= MR; a++) begin
      n = 0;
      @(negedge clk_i);
      while (!tx_start_strobe_o && n < TO + RG + 20) begin @(negedge clk_i); n++; end
      chk({tag, "_strobe_cyc"}, 64'(cyc), 64'(s_exp));
      chk({tag, "_tx_id"}, 64'(tx_id_o), 64'(ids[w]));
      chk({tag, "_tx_data"}, tx_data_o, dats[w]);
      chk({tag, "_busy"}, 64'(busy_o), 64'd1);
      d = (g_oc[a] == 2) ? TO - 1 : g_dly[a];
      for (int i = 0; i < d; i++) begin
        @(negedge clk_i);
        if (i == 0) chk({tag, "_strobe_1cyc"}, 64'(tx_start_strobe_o), 64'd0);
      end
      tx_succeed_i = (g_oc[a] == 0 || g_oc[a] == 3);
      tx_failed_i  = (g_oc[a] == 1 || g_oc[a] == 3);
      step();
      tx_succeed_i = 1'b0;
      tx_failed_i  = 1'b0;
      @(negedge clk_i);
      if (g_oc[a] == 0 || g_oc[a] == 3) begin
        chk({tag, "_done"}, 64'(done_o), 64'(1) << w);
        chk({tag, "_nofail"}, 64'(fail_o), 64'd0);
        chk({tag, "_idle"}, 64'(busy_o), 64'd0);
        exp_ok++;
        return;
      end else if (a == MR) begin
        chk({tag, "_fail"}, 64'(fail_o), 64'(1) << w);
        chk({tag, "_nodone"}, 64'(done_o), 64'd0);
        chk({tag, "_idle"}, 64'(busy_o), 64'd0);
        exp_ab++;
        return;
      end else begin
        chk({tag, "_retry_quiet"}, 64'({done_o, fail_o}), 64'd0);
        chk({tag, "_retry_busy"}, 64'(busy_o), 64'd1);
        s_exp = cyc + RG + 1;
      end
    end
  endtask

  task automatic script(input int nf, input int kind_fail, input int kind_ok, input int dly);
    for (int a = 0; a <= MR; a++) begin
      g_oc[a]  = (a < nf) ? kind_fail : kind_ok;
      g_dly[a] = dly;
    end
  endtask

  initial begin
    int cs, w;
    logic [NR-1:0] rem;
    rst_i = 1'b1;
    req_i = '0;
    req_id_i = '0;
    req_data_i = '0;
    tx_succeed_i = 1'b0;
    tx_failed_i = 1'b0;
    repeat (3) step();
    @(negedge clk_i);
    chk("rst_outs", 64'({ack_o, done_o, fail_o, busy_o, tx_start_strobe_o}), 64'd0);
    chk("rst_id", 64'(tx_id_o), 64'd0);
    chk("rst_data", tx_data_o, 64'd0);
    chk("rst_cnt", 64'({tx_ok_cnt_o, tx_fail_cnt_o}), 64'd0);
    step();
    rst_i = 1'b0;
    step();

    // single request, completion 20 cycles after the strobe
    set_req(0, 11'h352, 64'h1122334455667788);
    cs = cyc;
    wait_ack(0, cs + 1, "single");
    script(0, 1, 0, 20);
    serve(0, "single");

    // priority: lower ID wins regardless of index
    step();
    set_req(1, 11'h100, 64'hAAAA0001);
    set_req(2, 11'h0FF, 64'hBBBB0002);
    cs = cyc;
    wait_ack(2, cs + 1, "prio_a");
    script(0, 1, 0, 3);
    serve(2, "prio_a");
    wait_ack(1, cyc + 1, "prio_b");
    serve(1, "prio_b");

    // equal IDs: lower index wins
    step();
    set_req(0, 11'h200, 64'hC0);
    set_req(3, 11'h200, 64'hC3);
    cs = cyc;
    wait_ack(0, cs + 1, "tie_a");
    serve(0, "tie_a");
    wait_ack(3, cyc + 1, "tie_b");
    serve(3, "tie_b");

    // every attempt fails, then two failures and a success, then watchdog, then both flags
    step();
    set_req(1, 11'h055, 64'hF00D);
    cs = cyc;
    wait_ack(1, cs + 1, "allfail");
    script(MR + 1, 1, 0, 2);
    serve(1, "allfail");
    step();
    set_req(2, 11'h066, 64'hBEEF);
    cs = cyc;
    wait_ack(2, cs + 1, "twofail");
    script(2, 1, 0, 4);
    serve(2, "twofail");
    step();
    set_req(3, 11'h077, 64'hDEAD);
    cs = cyc;
    wait_ack(3, cs + 1, "wdog");
    script(MR + 1, 2, 0, 0);
    serve(3, "wdog");
    step();
    set_req(0, 11'h011, 64'h1234);
    cs = cyc;
    wait_ack(0, cs + 1, "both");
    script(0, 1, 3, 1);
    serve(0, "both");

    // completion flags outside WAIT are ignored
    step();
    tx_succeed_i = 1'b1;
    tx_failed_i  = 1'b1;
    repeat (2) begin
      @(negedge clk_i);
      chk("spurious", 64'({ack_o, done_o, fail_o, busy_o, tx_start_strobe_o}), 64'd0);
    end
    step();
    tx_succeed_i = 1'b0;
    tx_failed_i  = 1'b0;

    // reset while waiting for completion
    set_req(1, 11'h123, 64'h5555);
    cs = cyc;
    wait_ack(1, cs + 1, "rst_wait");
    step();
    req_i[1] = 1'b0;
    @(negedge clk_i);
    chk("rst_wait_strobe", 64'(tx_start_strobe_o), 64'd1);
    rst_i = 1'b1;
    tx_succeed_i = 1'b1;
    step();
    rst_i = 1'b0;
    tx_succeed_i = 1'b0;
    @(negedge clk_i);
    chk("rst_wait_outs", 64'({ack_o, done_o, fail_o, busy_o, tx_start_strobe_o}), 64'd0);
    chk("rst_wait_id", 64'(tx_id_o), 64'd0);
    chk("rst_wait_cnt", 64'({tx_ok_cnt_o, tx_fail_cnt_o}), 64'd0);
    repeat (3) begin
      @(negedge clk_i);
      chk("rst_wait_quiet", 64'({done_o, fail_o, busy_o}), 64'd0);
    end
    exp_ok = 0;
    exp_ab = 0;

    // randomized rounds of simultaneous requests and attempt outcomes
    for (int r = 0; r < 12; r++) begin
      step();
      rem = NR'($urandom_range(1, (1 << NR) - 1));
      for (int k = 0; k < NR; k++)
        if (rem[k])
          set_req(k, ($urandom_range(0, 3) == 0) ? 11'h200 : 11'($urandom), {$urandom, $urandom});
      cs = cyc;
      for (int f = 0; rem != '0; f++) begin
        w = pick(rem);
        wait_ack(w, (f == 0) ? cs + 1 : cyc + 1, "rnd");
        for (int a = 0; a <= MR; a++) g_dly[a] = $urandom_range(0, 12);
        cs = $urandom_range(0, MR + 1);
        for (int a = 0; a <= MR; a++)
          g_oc[a] = (a < cs) ? (($urandom_range(0, 5) == 0) ? 2 : 1)
                             : (($urandom_range(0, 3) == 0) ? 3 : 0);
        serve(w, "rnd");
        rem[w] = 1'b0;
      end
    end

    step();
    step();
`ifdef CAN_TX_SCHED_STATS_EN
    chk("ok_cnt", 64'(tx_ok_cnt_o), 64'(exp_ok));
    chk("fail_cnt", 64'(tx_fail_cnt_o), 64'(exp_ab));
`else
    chk("ok_cnt", 64'(tx_ok_cnt_o), 64'd0);
    chk("fail_cnt", 64'(tx_fail_cnt_o), 64'd0);
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
